// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle widths, bit positions inside each
// bundle, bubble constants and the per-edge action chosen by the ID/EX register.
package pipe_pkg;

  localparam int WB_W  = 2;
  localparam int EX_W  = 4;
  localparam int MEM_W = 2;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int EX_ALUSRC   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_REGDST   = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;
  localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;
  localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } stage_act_e;

  // Stall outranks every bubble source; any flush or hazard turns the load into a bubble.
  function automatic stage_act_e next_act(input logic stall, input logic flush,
                                          input logic hazard);
    stage_act_e act;
    act = ACT_LOAD;
    if (stall)
      act = ACT_HOLD;
    else if (flush || hazard)
      act = ACT_BUBBLE;
    return act;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparison: a valid load in EX whose destination (rt) is read by the
// valid instruction currently in ID. Register 0 never creates a dependency.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);

  assign hazard = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush/hazard bubbles and a flush that
// is remembered across a stall. Define ID_EX_STATS_EN to add bubble_cnt_o.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [EX_W-1:0]   EX_i,
  input  logic [MEM_W-1:0]  MEM_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] RSaddr_i,
  input  logic [REG_AW-1:0] RTaddr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [MEM_W-1:0]  MEM_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic              RegDst_o,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] RSaddr_o,
  output logic [REG_AW-1:0] RTaddr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              valid_o,
  output logic              hazard_o
`ifdef ID_EX_STATS_EN
  , output logic [15:0]     bubble_cnt_o
`endif
);

  logic [EX_W-1:0] ex_q;
  logic            flush_pend;
  logic            flush_now;
  logic            hazard_raw;
  stage_act_e      act;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid    (valid_o),
    .ex_mem_read (MEM_o[MEM_READ]),
    .ex_rt       (RTaddr_o),
    .id_valid    (valid_i),
    .id_rs       (RSaddr_i),
    .id_rt       (RTaddr_i),
    .hazard      (hazard_raw)
  );

  assign flush_now = flush_i || flush_pend;
  assign act       = next_act(stall_i, flush_now, hazard_raw);

  // A stalled or flushed cycle must not freeze PC/IF-ID on behalf of a dying load.
  assign hazard_o = hazard_raw && !stall_i && !flush_now;

  assign ALUSrc_o = ex_q[EX_ALUSRC];
  assign ALUOp_o  = ex_q[EX_ALUOP_HI:EX_ALUOP_LO];
  assign RegDst_o = ex_q[EX_REGDST];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o     <= WB_BUBBLE;
      MEM_o    <= MEM_BUBBLE;
      ex_q     <= EX_BUBBLE;
      RSdata_o <= '0;
      RTdata_o <= '0;
      imm_o    <= '0;
      RSaddr_o <= '0;
      RTaddr_o <= '0;
      RDaddr_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD: begin
          WB_o     <= WB_i;
          MEM_o    <= MEM_i;
          ex_q     <= EX_i;
          RSdata_o <= RSdata_i;
          RTdata_o <= RTdata_i;
          imm_o    <= imm_i;
          RSaddr_o <= RSaddr_i;
          RTaddr_o <= RTaddr_i;
          RDaddr_o <= RDaddr_i;
          valid_o  <= valid_i;
        end
        ACT_BUBBLE: begin
          WB_o     <= WB_BUBBLE;
          MEM_o    <= MEM_BUBBLE;
          ex_q     <= EX_BUBBLE;
          RSdata_o <= '0;
          RTdata_o <= '0;
          imm_o    <= '0;
          RSaddr_o <= '0;
          RTaddr_o <= '0;
          RDaddr_o <= '0;
          valid_o  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Repeated flushes during one stall collapse into a single pending bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      flush_pend <= 1'b0;
    else if (stall_i)
      flush_pend <= flush_pend || flush_i;
    else
      flush_pend <= 1'b0;
  end

`ifdef ID_EX_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      bubble_cnt_o <= 16'd0;
    else if (act == ACT_BUBBLE && bubble_cnt_o != 16'hFFFF)
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
  end
`endif

endmodule
